// File: rtl/regfile_arb.sv
// ============================================================================
//  Module   : regfile_arb
//  Purpose  : Two-requester arbiter in front of a 1R/1W register file.
//             After reset it walks every entry writing zero (INIT), then
//             arbitrates requests (RUN): one read grant on the R port and one
//             write grant on the W port per cycle, round-robin on same-type
//             conflicts. Read data is returned one cycle after the grant.
//  Ports    : clk, reset            clock, asynchronous active-high reset
//             req_valid/we/addr/wdata[1:0]  per-requester request inputs
//             req_ready[1:0]        combinational grant, same cycle as valid
//             resp_valid/data[1:0]  registered read response
//             rf_R_addr/en, rf_R_data          regfile read port (async data)
//             rf_W_addr/en/data                regfile write port
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_arb #(
  parameter int N     = 32,
  parameter int WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_we,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][WIDTH-1:0]      req_wdata,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 resp_valid,
  output logic [1:0][WIDTH-1:0]      resp_data,
  output logic [ADDR_WIDTH-1:0]      rf_R_addr,
  output logic                       rf_R_en,
  input  logic [WIDTH-1:0]           rf_R_data,
  output logic [ADDR_WIDTH-1:0]      rf_W_addr,
  output logic                       rf_W_en,
  output logic [WIDTH-1:0]           rf_W_data
);

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(N - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  logic                    rr_ptr_q;
  logic                    rr_ptr_d;
  logic [1:0]              resp_valid_q;
  logic [1:0][WIDTH-1:0]   resp_data_q;

  logic                    w_run;
  logic                    w_init;
  logic                    w_conflict;
  logic [1:0]              w_rd_gnt;
  logic [1:0]              w_wr_gnt;

  // --------------------------------------------------------------------------
  // Grant logic. Reset gates everything so no grant or regfile write can leak
  // out while the asynchronous reset is being held.
  // --------------------------------------------------------------------------
  always_comb begin
    w_run      = (state_q == ST_RUN) && !reset;
    w_init     = (state_q == ST_INIT) && !reset;
    // Only two requests of the same kind compete; a read and a write use
    // different regfile ports and can both proceed.
    w_conflict = w_run && (&req_valid) && (req_we[0] == req_we[1]);

    req_ready = 2'b00;
    rr_ptr_d  = rr_ptr_q;
    if (w_conflict) begin
      req_ready[rr_ptr_q] = 1'b1;
      // The loser gets priority next time.
      rr_ptr_d            = ~rr_ptr_q;
    end else if (w_run) begin
      req_ready = req_valid;
    end

    w_rd_gnt = req_ready & ~req_we;
    w_wr_gnt = req_ready &  req_we;
  end

  // Read port: at most one bit of w_rd_gnt is ever set.
  always_comb begin
    rf_R_en   = |w_rd_gnt;
    rf_R_addr = '0;
    if (w_rd_gnt[1]) begin
      rf_R_addr = req_addr[1];
    end else if (w_rd_gnt[0]) begin
      rf_R_addr = req_addr[0];
    end
  end

  // Write port: INIT clears entry init_cnt_q; RUN forwards the write grant.
  always_comb begin
    rf_W_en   = 1'b0;
    rf_W_addr = '0;
    rf_W_data = '0;
    if (w_init) begin
      rf_W_en   = 1'b1;
      rf_W_addr = init_cnt_q;
    end else if (w_wr_gnt[1]) begin
      rf_W_en   = 1'b1;
      rf_W_addr = req_addr[1];
      rf_W_data = req_wdata[1];
    end else if (w_wr_gnt[0]) begin
      rf_W_en   = 1'b1;
      rf_W_addr = req_addr[0];
      rf_W_data = req_wdata[0];
    end
  end

  // --------------------------------------------------------------------------
  // State machine and registered responses.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      rr_ptr_q     <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == C_LAST_ADDR) begin
            state_q    <= ST_RUN;
            init_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          rr_ptr_q <= rr_ptr_d;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase

      // rf_R_data is sampled before the same-edge write commits, so a read
      // racing a write to the same entry returns the old contents.
      resp_valid_q <= w_rd_gnt;
      for (int i = 0; i < 2; i++) begin
        if (w_rd_gnt[i]) begin
          resp_data_q[i] <= rf_R_data;
        end
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_arb.sv
// ============================================================================
//  Module   : tb_regfile_arb
//  Purpose  : Self-checking bench for regfile_arb with an attached regfile
//             model, a behavioural reference model, directed scenarios and
//             randomized request traffic.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_arb;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int AW = 5;

  logic                clk;
  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0]          req_we;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][W-1:0]   req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          resp_valid;
  logic [1:0][W-1:0]   resp_data;
  logic [AW-1:0]       rf_R_addr;
  logic                rf_R_en;
  logic [W-1:0]        rf_R_data;
  logic [AW-1:0]       rf_W_addr;
  logic                rf_W_en;
  logic [W-1:0]        rf_W_data;

  regfile_arb #(.N(N), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .rf_R_addr  (rf_R_addr),
    .rf_R_en    (rf_R_en),
    .rf_R_data  (rf_R_data),
    .rf_W_addr  (rf_W_addr),
    .rf_W_en    (rf_W_en),
    .rf_W_data  (rf_W_data)
  );

  // Register file attached to the DUT: async read, write at rising edge.
  logic [W-1:0] rf_mem [N];
  initial begin
    for (int i = 0; i < N; i++) rf_mem[i] = $urandom;
  end
  always @(posedge clk) begin
    if (rf_W_en) rf_mem[rf_W_addr] <= rf_W_data;
  end
  assign rf_R_data = rf_mem[rf_R_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: cycles since reset release, a memory image, the
  // round-robin owner and the expected response registers.
  // --------------------------------------------------------------------------
  int           m_since;
  logic [W-1:0] m_mem [N];
  bit           m_rr;
  logic [1:0]   m_rv;
  logic [W-1:0] m_rd [2];

  always @(negedge clk) begin
    logic [1:0] gnt;
    int r, w;
    if (reset) begin
      m_since = 0;
      m_rr    = 1'b0;
      m_rv    = 2'b00;
      m_rd[0] = '0;
      m_rd[1] = '0;
      chk("rst_ready", req_ready, 0);
      chk("rst_wen",   rf_W_en, 0);
      chk("rst_rvalid", resp_valid, 0);
      chk("rst_rdata0", resp_data[0], 0);
      chk("rst_rdata1", resp_data[1], 0);
    end else begin
      chk("m_rvalid", resp_valid, m_rv);
      chk("m_rdata0", resp_data[0], m_rd[0]);
      chk("m_rdata1", resp_data[1], m_rd[1]);
      m_rv = 2'b00;
      if (m_since < N) begin
        chk("m_init_ready", req_ready, 0);
        chk("m_init_ren",   rf_R_en, 0);
        chk("m_init_wen",   rf_W_en, 1);
        chk("m_init_waddr", rf_W_addr, m_since);
        chk("m_init_wdata", rf_W_data, 0);
        m_mem[m_since] = '0;
        m_since++;
      end else begin
        if (req_valid == 2'b11 && req_we[0] == req_we[1]) begin
          gnt  = m_rr ? 2'b10 : 2'b01;
          m_rr = !m_rr;
        end else begin
          gnt = req_valid;
        end
        chk("m_ready", req_ready, gnt);
        r = -1;
        w = -1;
        for (int i = 0; i < 2; i++) begin
          if (gnt[i] && !req_we[i]) r = i;
          if (gnt[i] &&  req_we[i]) w = i;
        end
        chk("m_ren", rf_R_en, (r >= 0));
        chk("m_wen", rf_W_en, (w >= 0));
        if (r >= 0) begin
          chk("m_raddr", rf_R_addr, req_addr[r]);
          m_rv[r] = 1'b1;
          m_rd[r] = m_mem[req_addr[r]];
        end
        if (w >= 0) begin
          chk("m_waddr", rf_W_addr, req_addr[w]);
          chk("m_wdata", rf_W_data, req_wdata[w]);
          m_mem[req_addr[w]] = req_wdata[w];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // --------------------------------------------------------------------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int i, bit v, bit we, int a, logic [W-1:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i]  = AW'(a);
    req_wdata[i] = d;
  endtask

  task automatic idle();
    req_valid = 2'b00;
  endtask

  // Release reset and check the N-cycle clearing walk, then first RUN cycle.
  task automatic release_and_check_init(string tag);
    int nw;
    next_cyc();
    reset = 1'b0;
    nw = 0;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      if (rf_W_en === 1'b1 && rf_W_addr === AW'(c) && rf_W_data === '0) nw++;
    end
    chk({tag, "_init_writes"}, nw, N);
    @(negedge clk);
    chk({tag, "_run_wen0"}, rf_W_en, 0);
  endtask

  logic [1:0] exp_g [4];
  logic [1:0] acc;

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1 reset = 1'b1;
    repeat (3) next_cyc();

    // Clearing walk after power-up reset.
    release_and_check_init("por");

    // Write then read back through requester 0.
    next_cyc();
    drive(0, 1, 1, 5, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr5_ready", req_ready, 2'b01);
    chk("wr5_waddr", rf_W_addr, 5);
    chk("wr5_wdata", rf_W_data, 32'hDEADBEEF);
    next_cyc();
    drive(0, 1, 0, 5, 0);
    @(negedge clk);
    chk("rd5_ready", req_ready, 2'b01);
    chk("rd5_ren", rf_R_en, 1);
    next_cyc();
    idle();
    @(negedge clk);
    chk("rd5_rvalid", resp_valid, 2'b01);
    chk("rd5_rdata", resp_data[0], 32'hDEADBEEF);
    next_cyc();
    @(negedge clk);
    chk("rd5_rvalid_drop", resp_valid, 2'b00);
    chk("rd5_rdata_hold", resp_data[0], 32'hDEADBEEF);

    // Two competing reads held for four cycles: grants alternate.
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    next_cyc();
    drive(0, 1, 0, 1, 0);
    drive(1, 1, 0, 2, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant", req_ready, exp_g[k]);
      if (k > 0) chk("rr_rvalid", resp_valid, exp_g[k-1]);
      next_cyc();
    end
    idle();
    @(negedge clk);
    chk("rr_rvalid_last", resp_valid, exp_g[3]);

    // Read and write of the same entry in one cycle: read sees old data.
    next_cyc();
    drive(0, 1, 1, 7, 32'h11);
    next_cyc();
    drive(0, 1, 0, 7, 0);
    drive(1, 1, 1, 7, 32'h22);
    @(negedge clk);
    chk("rw7_ready", req_ready, 2'b11);
    next_cyc();
    idle();
    @(negedge clk);
    chk("rw7_old", resp_data[0], 32'h11);
    next_cyc();
    drive(1, 1, 0, 7, 0);
    next_cyc();
    idle();
    @(negedge clk);
    chk("rw7_new_valid", resp_valid, 2'b10);
    chk("rw7_new", resp_data[1], 32'h22);

    // Reset lands between a read accept and its response edge.
    next_cyc();
    drive(0, 1, 0, 7, 0);
    @(negedge clk);
    chk("rst_rd_ready", req_ready, 2'b01);
    #1 reset = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_drop_valid", resp_valid, 2'b00);
    chk("rst_drop_data", resp_data[0], 0);
    next_cyc();
    release_and_check_init("mid");
    next_cyc();
    drive(0, 1, 0, 7, 0);
    next_cyc();
    idle();
    @(negedge clk);
    chk("mid_rd7_valid", resp_valid, 2'b01);
    chk("mid_rd7_zero", resp_data[0], 0);

    // Randomized traffic; requests hold until accepted. One reset mid-run.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      next_cyc();
      if (k == 300) reset = 1'b1;
      if (k == 303) reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || acc[i]) begin
          if ($urandom_range(0, 9) < 6)
            drive(i, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
          else
            req_valid[i] = 1'b0;
        end
      end
    end
    next_cyc();
    idle();
    repeat (3) next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
